// File: rtl/ib_lut_bank_array.sv
// Multi-bank, multi-page LUT RAM for information-bottleneck node tables.
// Independent registered read ports plus a streaming page loader with hazard flags.
module ib_lut_bank_array #(
  parameter int DATA_W      = 3,
  parameter int BANK_NUM    = 2,
  parameter int PAGE_NUM    = 2,
  parameter int PAGE_ADDR_W = 4,
  parameter int READ_PORTS  = 4,
  localparam int BANK_W     = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1,
  localparam int PAGE_W     = (PAGE_NUM > 1) ? $clog2(PAGE_NUM) : 1
) (
  input  logic                              sys_clk,
  input  logic                              rst,
  input  logic [READ_PORTS-1:0]             rd_en,
  input  logic [READ_PORTS*BANK_W-1:0]      rd_bank,
  input  logic [READ_PORTS*PAGE_W-1:0]      rd_page,
  input  logic [READ_PORTS*PAGE_ADDR_W-1:0] rd_addr,
  output logic [READ_PORTS*DATA_W-1:0]      rd_data,
  output logic [READ_PORTS-1:0]             rd_valid,
  output logic [READ_PORTS-1:0]             rd_hazard,
  input  logic                              ld_start,
  input  logic [PAGE_W-1:0]                 ld_page,
  input  logic [DATA_W-1:0]                 ld_data,
  input  logic                              ld_valid,
  output logic                              ld_ready,
  output logic                              ld_busy,
  output logic                              ld_done,
  output logic                              ld_err
);

  localparam int DEPTH = 1 << PAGE_ADDR_W;
  localparam int WORDS = BANK_NUM * DEPTH;
  localparam int CNT_W = BANK_W + PAGE_ADDR_W + 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WORDS - 1);
  localparam logic [BANK_W:0]   BANK_LIM = (BANK_W + 1)'(BANK_NUM);
  localparam logic [PAGE_W:0]   PAGE_LIM = (PAGE_W + 1)'(PAGE_NUM);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE
  } ld_state_e;

  ld_state_e               state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [PAGE_W-1:0]       page_q, page_d;
  logic                    err_q, err_d;
  logic                    wr_en;
  logic [BANK_W-1:0]       wr_bank;
  logic [PAGE_ADDR_W-1:0]  wr_addr;

  logic [DATA_W-1:0] mem [BANK_NUM][PAGE_NUM][DEPTH];

  // Entry address is the low counter field, bank the field above it.
  always_comb begin
    wr_addr = cnt_q[PAGE_ADDR_W-1:0];
    wr_bank = cnt_q[PAGE_ADDR_W +: BANK_W];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    page_d  = page_q;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ld_start) begin
          if ({1'b0, ld_page} < PAGE_LIM) begin
            state_d = ST_LOAD;
            page_d  = ld_page;
            cnt_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        err_d = ld_start;
        if (ld_valid) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        err_d   = ld_start;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      page_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      page_q  <= page_d;
      err_q   <= err_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[wr_bank][page_q][wr_addr] <= ld_data;
  end

  always_comb begin
    ld_ready = (state_q == ST_LOAD);
    ld_busy  = (state_q != ST_IDLE);
    ld_done  = (state_q == ST_DONE);
    ld_err   = err_q;
  end

  for (genvar gi = 0; gi < READ_PORTS; gi++) begin : g_rd
    logic [BANK_W-1:0]      bank;
    logic [PAGE_W-1:0]      page;
    logic [PAGE_ADDR_W-1:0] addr;
    logic                   in_range;
    logic [DATA_W-1:0]      data_q, data_d;
    logic                   valid_q, hazard_q, hazard_d;

    always_comb begin
      bank     = rd_bank[gi*BANK_W +: BANK_W];
      page     = rd_page[gi*PAGE_W +: PAGE_W];
      addr     = rd_addr[gi*PAGE_ADDR_W +: PAGE_ADDR_W];
      in_range = ({1'b0, bank} < BANK_LIM) && ({1'b0, page} < PAGE_LIM);
    end

    // Memory is read pre-edge, so a same-cycle loader write shows up on the next read.
    always_comb begin
      data_d   = data_q;
      hazard_d = rd_en[gi] & ld_busy & in_range & (page == page_q);
      if (rd_en[gi]) data_d = in_range ? mem[bank][page][addr] : '0;
    end

    always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
        data_q   <= '0;
        valid_q  <= 1'b0;
        hazard_q <= 1'b0;
      end else begin
        data_q   <= data_d;
        valid_q  <= rd_en[gi];
        hazard_q <= hazard_d;
      end
    end

    always_comb begin
      rd_data[gi*DATA_W +: DATA_W] = data_q;
      rd_valid[gi]                 = valid_q;
      rd_hazard[gi]                = hazard_q;
    end
  end

endmodule

// File: tb/tb_ib_lut_bank_array.sv
// Bench for ib_lut_bank_array: three parameter sets, each driven by directed
// scenarios and random traffic and scored against an array-based model.
module tb_ib_lut_bank_array;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int unsigned n_checks   = 0;
  int unsigned n_errors   = 0;
  int unsigned n_cfg_done = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int DW    = (g == 1) ? 5 : 3;
    localparam int BN    = (g == 0) ? 2 : ((g == 1) ? 4 : 3);
    localparam int PN    = (g == 0) ? 2 : ((g == 1) ? 4 : 3);
    localparam int AW    = 4;
    localparam int RP    = (g == 1) ? 8 : 4;
    localparam int BW    = (BN > 1) ? $clog2(BN) : 1;
    localparam int PW    = (PN > 1) ? $clog2(PN) : 1;
    localparam int DEPTH = 1 << AW;
    localparam int TOTAL = BN * DEPTH;

    logic             rst;
    logic [RP-1:0]    rd_en, rd_valid, rd_hazard;
    logic [RP*BW-1:0] rd_bank;
    logic [RP*PW-1:0] rd_page;
    logic [RP*AW-1:0] rd_addr;
    logic [RP*DW-1:0] rd_data;
    logic             ld_start, ld_valid, ld_ready, ld_busy, ld_done, ld_err;
    logic [PW-1:0]    ld_page;
    logic [DW-1:0]    ld_data;

    ib_lut_bank_array #(
      .DATA_W(DW), .BANK_NUM(BN), .PAGE_NUM(PN), .PAGE_ADDR_W(AW), .READ_PORTS(RP)
    ) u_dut (
      .sys_clk(sys_clk), .rst(rst),
      .rd_en(rd_en), .rd_bank(rd_bank), .rd_page(rd_page), .rd_addr(rd_addr),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_hazard(rd_hazard),
      .ld_start(ld_start), .ld_page(ld_page), .ld_data(ld_data), .ld_valid(ld_valid),
      .ld_ready(ld_ready), .ld_busy(ld_busy), .ld_done(ld_done), .ld_err(ld_err)
    );

    // Reference model: the table contents plus a loader described as
    // "loading page m_page, m_cnt words so far" / "finishing".
    logic [DW-1:0] m_mem   [BN][PN][DEPTH];
    bit            m_known [BN][PN][DEPTH];
    bit            m_load, m_done;
    int            m_page, m_cnt;
    logic [DW-1:0] e_data   [RP];
    bit            e_dknown [RP];
    bit            e_valid  [RP];
    bit            e_haz    [RP];
    bit            e_err;

    task automatic set_port(input int i, input bit en, input int b, input int p, input int a);
      rd_en[i]             = en;
      rd_bank[i*BW +: BW]  = BW'(b);
      rd_page[i*PW +: PW]  = PW'(p);
      rd_addr[i*AW +: AW]  = AW'(a);
    endtask

    task automatic ports_off();
      for (int i = 0; i < RP; i++) set_port(i, 1'b0, 0, 0, 0);
    endtask

    task automatic check_outs(input string tag);
      for (int i = 0; i < RP; i++) begin
        check($sformatf("c%0d %s rd_valid[%0d]", g, tag, i), 64'(rd_valid[i]), 64'(e_valid[i]));
        check($sformatf("c%0d %s rd_hazard[%0d]", g, tag, i), 64'(rd_hazard[i]), 64'(e_haz[i]));
        if (e_dknown[i])
          check($sformatf("c%0d %s rd_data[%0d]", g, tag, i), 64'(rd_data[i*DW +: DW]), 64'(e_data[i]));
      end
      check($sformatf("c%0d %s ld_ready", g, tag), 64'(ld_ready), 64'(m_load));
      check($sformatf("c%0d %s ld_busy", g, tag), 64'(ld_busy), 64'(m_load | m_done));
      check($sformatf("c%0d %s ld_done", g, tag), 64'(ld_done), 64'(m_done));
      check($sformatf("c%0d %s ld_err", g, tag), 64'(ld_err), 64'(e_err));
    endtask

    task automatic reset_model();
      if (m_load)
        for (int b = 0; b < BN; b++)
          for (int a = 0; a < DEPTH; a++) m_known[b][m_page][a] = 1'b0;
      m_load = 1'b0;
      m_done = 1'b0;
      e_err  = 1'b0;
      for (int i = 0; i < RP; i++) begin
        e_data[i] = '0; e_dknown[i] = 1'b1; e_valid[i] = 1'b0; e_haz[i] = 1'b0;
      end
    endtask

    // Predict the effect of the current inputs over one clock edge, then compare.
    task automatic tick(input string tag);
      int b, p, a;
      bit err;
      for (int i = 0; i < RP; i++) begin
        b = int'(rd_bank[i*BW +: BW]);
        p = int'(rd_page[i*PW +: PW]);
        a = int'(rd_addr[i*AW +: AW]);
        e_valid[i] = rd_en[i];
        e_haz[i]   = rd_en[i] && (m_load || m_done) && b < BN && p < PN && p == m_page;
        if (rd_en[i]) begin
          if (b >= BN || p >= PN) begin
            e_data[i] = '0; e_dknown[i] = 1'b1;
          end else begin
            e_data[i] = m_mem[b][p][a]; e_dknown[i] = m_known[b][p][a];
          end
        end
      end
      err = 1'b0;
      if (m_load) begin
        if (ld_valid) begin
          m_mem[m_cnt / DEPTH][m_page][m_cnt % DEPTH]   = ld_data;
          m_known[m_cnt / DEPTH][m_page][m_cnt % DEPTH] = 1'b1;
          m_cnt++;
          if (m_cnt == TOTAL) begin m_load = 1'b0; m_done = 1'b1; end
        end
        err = ld_start;
      end else if (m_done) begin
        m_done = 1'b0;
        err    = ld_start;
      end else if (ld_start) begin
        if (int'(ld_page) < PN) begin
          m_load = 1'b1; m_page = int'(ld_page); m_cnt = 0;
        end else begin
          err = 1'b1;
        end
      end
      e_err = err;
      @(posedge sys_clk);
      #1;
      check_outs(tag);
    endtask

    task automatic finish_load(input string tag, output bit seen_done);
      int guard;
      guard     = 0;
      seen_done = 1'b0;
      ld_valid  = 1'b1;
      while ((m_load || m_done) && guard < 4 * TOTAL) begin
        ld_data = DW'($urandom);
        tick(tag);
        if (ld_done) seen_done = 1'b1;
        guard++;
      end
      ld_valid = 1'b0;
      check($sformatf("c%0d %s idle", g, tag), 64'(ld_busy), 64'd0);
    endtask

    initial begin : run
      int guard, ready_cycles, slots, rd_at;
      bit seen;
      rst = 1'b1; ld_start = 1'b0; ld_valid = 1'b0; ld_page = '0; ld_data = '0;
      rd_en = '0; rd_bank = '0; rd_page = '0; rd_addr = '0;
      m_load = 1'b0; m_done = 1'b0; m_page = 0; m_cnt = 0;
      for (int b = 0; b < BN; b++)
        for (int p = 0; p < PN; p++)
          for (int a = 0; a < DEPTH; a++) m_known[b][p][a] = 1'b0;
      repeat (2) @(posedge sys_clk);
      #1;
      reset_model();
      check_outs("reset");
      rst = 1'b0;

      // Page 0 filled with word n = n mod 2^DW, valid held high.
      ld_start = 1'b1; ld_page = '0; tick("ld1_start"); ld_start = 1'b0;
      ld_valid = 1'b1; guard = 0; ready_cycles = 0;
      while (m_load && guard < 4 * TOTAL) begin
        ld_data = DW'(m_cnt);
        if (ld_ready) ready_cycles++;
        tick("ld1");
        guard++;
      end
      check($sformatf("c%0d ld1 ready_cycles", g), 64'(ready_cycles), 64'(TOTAL));
      check($sformatf("c%0d ld1 done_now", g), 64'(ld_done), 64'd1);
      ld_valid = 1'b0;
      tick("ld1_tail");
      for (int i = 0; i < RP; i++) set_port(i, 1'b1, 1, 0, 5);
      tick("rd_b1a5");
      for (int i = 0; i < RP; i++)
        check($sformatf("c%0d b1a5[%0d]", g, i), 64'(rd_data[i*DW +: DW]), 64'((DEPTH + 5) % (1 << DW)));
      check($sformatf("c%0d b1a5 valid", g), 64'(rd_valid), 64'((1 << RP) - 1));
      ports_off();

      // Page 1 with ld_valid toggling; port 2 reads page 1, port 3 reads page 0.
      ld_start = 1'b1; ld_page = PW'(1); tick("ld2_start"); ld_start = 1'b0;
      guard = 0; slots = 0;
      while ((m_load || m_done) && guard < 8 * TOTAL) begin
        ld_valid = guard[0];
        ld_data  = DW'($urandom);
        set_port(2, 1'b1, $urandom_range(0, BN - 1), 1, $urandom_range(0, DEPTH - 1));
        set_port(3, 1'b1, $urandom_range(0, BN - 1), 0, $urandom_range(0, DEPTH - 1));
        if (ld_ready) slots++;
        tick("ld2");
        if (guard == 5) check($sformatf("c%0d ld2 haz_pattern", g), 64'(rd_hazard), 64'(1) << 2);
        guard++;
      end
      check($sformatf("c%0d ld2 slots", g), 64'(slots), 64'(2 * TOTAL));
      ld_valid = 1'b0;
      tick("ld2_after");
      check($sformatf("c%0d ld2 haz_clear", g), 64'(rd_hazard), 64'd0);
      ports_off();

      // Page 0 reloaded with word n = (n+3) mod 2^DW; read word 3 as it is written.
      ld_start = 1'b1; ld_page = '0; tick("ld3_start"); ld_start = 1'b0;
      guard = 0;
      while ((m_load || m_done) && guard < 4 * TOTAL) begin
        rd_at    = m_load ? m_cnt : -1;
        ld_valid = 1'b1;
        ld_data  = DW'(m_cnt + 3);
        set_port(0, (rd_at == 3 || rd_at == 4), 0, 0, 3);
        ld_start = (rd_at == 10);
        tick("ld3");
        if (rd_at == 3)  check($sformatf("c%0d rbw_old", g), 64'(rd_data[DW-1:0]), 64'd3);
        if (rd_at == 4)  check($sformatf("c%0d rbw_new", g), 64'(rd_data[DW-1:0]), 64'(6 % (1 << DW)));
        if (rd_at == 10) check($sformatf("c%0d err_in_load", g), 64'(ld_err), 64'd1);
        guard++;
      end
      ld_start = 1'b0; ld_valid = 1'b0;
      ports_off();
      tick("ld3_tail");

      // Highest encodable page: rejected only when it is not a real page.
      ld_start = 1'b1; ld_page = '1; tick("maxpage"); ld_start = 1'b0;
      check($sformatf("c%0d maxpage err", g), 64'(ld_err), 64'(((1 << PW) - 1) >= PN));
      finish_load("maxpage_fin", seen);

      // Reset ten words into a load, then a clean full load.
      ld_start = 1'b1; ld_page = PW'(1); tick("ld4_start"); ld_start = 1'b0;
      ld_valid = 1'b1; guard = 0;
      while (m_cnt < 10 && guard < 4 * TOTAL) begin
        ld_data = DW'($urandom);
        tick("ld4");
        guard++;
      end
      ld_valid = 1'b0;
      rst = 1'b1;
      #1;
      reset_model();
      check_outs("rst_async");
      @(posedge sys_clk);
      #1;
      check_outs("rst_hold");
      rst = 1'b0;
      ld_start = 1'b1; ld_page = PW'(1); tick("ld5_start"); ld_start = 1'b0;
      finish_load("ld5", seen);
      check($sformatf("c%0d ld5 done_seen", g), 64'(seen), 64'd1);

      // Random traffic on every port with occasional loads.
      for (int c = 0; c < 400; c++) begin
        for (int i = 0; i < RP; i++)
          set_port(i, $urandom_range(0, 1), $urandom_range(0, (1 << BW) - 1),
                   $urandom_range(0, (1 << PW) - 1), $urandom_range(0, DEPTH - 1));
        ld_start = ($urandom_range(0, 15) == 0);
        ld_page  = PW'($urandom);
        ld_valid = ($urandom_range(0, 3) != 0);
        ld_data  = DW'($urandom);
        tick("rand");
      end
      ld_start = 1'b0;
      ports_off();
      finish_load("rand_fin", seen);
      n_cfg_done++;
    end
  end

  initial begin : summary
    for (int t = 0; t < 20000 && n_cfg_done < 3; t++) @(posedge sys_clk);
    #2;
    check("all_cfg_done", 64'(n_cfg_done), 64'd3);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
